pmod_input_conditioner: RTL and testbench
=========================================

Name: pmod_input_conditioner

Overview:
- Upstream front-end for the nibble accumulator. It conditions raw PMOD button and data-switch pins before the accumulator sees them.
- Per button: 2-flop synchronizer, tick-based debouncer, and clean one-cycle press/release pulses.
- Captures the 4-bit data nibble at the instant the "add" press is accepted. The accumulator can then use one press pulse per add instead of its own slow-clock edge logic.

Parameters:
- TICK_DIV, 12000: clk cycles per debounce tick (1 ms at 12 MHz); must be >= 2.
- DEBOUNCE_TICKS, 10: consecutive ticks a new level must hold before it is accepted; must be >= 1.
- NBTN, 4: number of button inputs.
- DW, 4: data nibble width.
- ADD_IDX, 1: index of the button whose press captures data.
- REPEAT_DELAY_TICKS, 500: hold time before the first auto-repeat (feature only).
- REPEAT_RATE_TICKS, 100: auto-repeat period (feature only).

Ports:
- clk, input, 1: system clock, 12 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- btn_raw, input, NBTN: raw asynchronous button pins.
- data_raw, input, DW: raw asynchronous data switch pins.
- tick, output, 1: one-cycle debounce tick strobe.
- btn_level, output, NBTN: debounced button levels.
- btn_press, output, NBTN: one-cycle pulse on an accepted rising edge.
- btn_release, output, NBTN: one-cycle pulse on an accepted falling edge.
- data_q, output, DW: data nibble captured at the add press.
- data_valid, output, 1: one-cycle pulse, coincident with btn_press[ADD_IDX].

Behaviour:
- Reset:
  - rst_n low asynchronously clears all outputs, synchronizers, the prescaler, debounce counters and FSMs.
  - All outputs are 0 during reset and on the first cycle after release.
- Synchronizer:
  - btn_raw and data_raw each pass through 2 flops; "sync" below means the second stage.
  - Latency is 2 clk from pin to sync.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is high for exactly 1 clk when the count equals TICK_DIV-1.
  - First tick occurs TICK_DIV cycles after reset release.
- Per-button FSM, states STABLE_LO, PEND_HI, STABLE_HI, PEND_LO:
  - STABLE_LO: if sync=1, go to PEND_HI and clear cnt.
  - PEND_HI: if sync=0 at any clk, return to STABLE_LO with no output (bounce rejected). On each tick with sync=1, cnt++. When cnt reaches DEBOUNCE_TICKS, go to STABLE_HI.
  - STABLE_HI and PEND_LO: mirror image of the above.
  - Counter width is $clog2(DEBOUNCE_TICKS+1). The counter saturates and never wraps.
- Output timing:
  - btn_level is registered and updates on the clk edge that enters STABLE_HI or STABLE_LO.
  - btn_press (resp. btn_release) is high for exactly that one cycle.
- Press/release pulses are mutually exclusive per button. Buttons are fully independent; simultaneous presses on several buttons give simultaneous pulses.
- Data capture:
  - On the cycle btn_press[ADD_IDX] asserts, data_q loads the data sync value from the same deciding clk.
  - data_valid is high for that cycle only.
  - data_q holds its value otherwise, including across release.
- Other cases:
  - A button held at reset release is debounced normally and produces one btn_press about DEBOUNCE_TICKS ticks later.
  - Reset asserted mid-pending aborts the FSM; no pulse is emitted.
  - A pulse shorter than 1 tick period is never accepted.

Optional Feature:
- Macro: PMOD_AUTO_REPEAT_EN.
- Defined:
  - While the button ADD_IDX is in STABLE_HI, a repeat counter runs on tick.
  - After REPEAT_DELAY_TICKS ticks it emits an extra btn_press[ADD_IDX] and data_valid, with a fresh data_q capture.
  - It then emits the same every REPEAT_RATE_TICKS ticks.
  - The counter clears when the button leaves STABLE_HI.
  - No btn_release is generated for repeats.
- Undefined: no repeat logic; exactly one press pulse per accepted press.

Test Plan (TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2):
- Reset release, all inputs 0 -> all outputs 0; tick first at cycle 4 after release, then every 4 cycles.
- btn_raw[1]=1 held, data_raw=4'hA -> exactly one btn_press[1] and one data_valid after 3 ticks; data_q=4'hA; btn_level[1]=1.
- btn_raw[0] toggled 1 for 5 clk then 0 (bounce shorter than debounce) -> no pulse; btn_level[0] stays 0.
- From level 1, btn_raw[1]=0 held -> one btn_release[1] after 3 ticks; no press pulse; data_q unchanged.
- rst_n pulsed low while btn_raw[2]=1 is pending -> outputs clear asynchronously, no pulse during reset; with the input still held, one btn_press[2] 3 ticks after re-debounce.
- With PMOD_AUTO_REPEAT_EN, hold btn 1 for 12 ticks with data changing 1,2,3 -> presses at accept, +5 ticks, then every 2 ticks; each data_q matches data_raw at that pulse. Without the macro -> a single press.

Source files
------------

// File: rtl/pmod_input_conditioner.sv
// pmod_input_conditioner
// Front-end for the nibble accumulator. Each raw PMOD button is synchronized,
// debounced on a slow tick and turned into one-cycle press/release pulses.
// The data nibble is captured when a press of the "add" button is accepted.
// Optional build macro: PMOD_AUTO_REPEAT_EN adds auto-repeat of the add press
// while that button is held.
module pmod_input_conditioner #(
  parameter int TICK_DIV           = 12000,
  parameter int DEBOUNCE_TICKS     = 10,
  parameter int NBTN               = 4,
  parameter int DW                 = 4,
  parameter int ADD_IDX            = 1,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] btn_raw,
  input  logic [DW-1:0]   data_raw,
  output logic            tick,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [DW-1:0]   data_q,
  output logic            data_valid
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  // Elaboration-time parameter sanity checks.
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be >= 2");
  end
  if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
    $error("DEBOUNCE_TICKS must be >= 1");
  end
  if ((ADD_IDX < 0) || (ADD_IDX >= NBTN)) begin : g_bad_add_idx
    $error("ADD_IDX must index a button");
  end
  if ((REPEAT_DELAY_TICKS < 1) || (REPEAT_RATE_TICKS < 1)) begin : g_bad_repeat
    $error("repeat tick counts must be >= 1");
  end

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_t;

  logic [NBTN-1:0] btn_sync_p0, btn_sync_p1;
  logic [DW-1:0]   data_sync_p0, data_sync_p1;
  logic [PW-1:0]   ps_cnt;

  db_state_t       state     [NBTN];
  db_state_t       state_nxt [NBTN];
  logic [CW-1:0]   cnt       [NBTN];
  logic [CW-1:0]   cnt_nxt   [NBTN];
  logic [NBTN-1:0] level_nxt, press_nxt, release_nxt;
  logic [NBTN-1:0] rpt_vec;
  logic            rpt_fire;
  logic            capture;

  // ---- stage p0/p1: two-flop synchronizers for buttons and data pins ----
  // Metastability guard: raw pins land in p0, the settled value is p1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_p0  <= '0;
      btn_sync_p1  <= '0;
      data_sync_p0 <= '0;
      data_sync_p1 <= '0;
    end else begin
      btn_sync_p0  <= btn_raw;
      btn_sync_p1  <= btn_sync_p0;
      data_sync_p0 <= data_raw;
      data_sync_p1 <= data_sync_p0;
    end
  end

  // Prescaler: tick is registered, so it is high for the clk after the count hits its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
      tick   <= 1'b0;
    end else if (ps_cnt == PS_LAST) begin
      ps_cnt <= '0;
      tick   <= 1'b1;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
      tick   <= 1'b0;
    end
  end

  // Debounce next-state: a new level must survive DEBOUNCE_TICKS ticks without a single bounce.
  always_comb begin
    level_nxt   = '0;
    press_nxt   = '0;
    release_nxt = '0;
    for (int i = 0; i < NBTN; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        STABLE_LO: begin
          if (btn_sync_p1[i]) begin
            state_nxt[i] = PEND_HI;
            cnt_nxt[i]   = '0;
          end
        end
        PEND_HI: begin
          if (!btn_sync_p1[i]) begin
            state_nxt[i] = STABLE_LO;
          end else if (tick) begin
            if (cnt[i] >= CNT_LAST) begin
              state_nxt[i] = STABLE_HI;
              cnt_nxt[i]   = CNT_DONE;
            end else begin
              cnt_nxt[i] = cnt[i] + 1'b1;
            end
          end
        end
        STABLE_HI: begin
          if (!btn_sync_p1[i]) begin
            state_nxt[i] = PEND_LO;
            cnt_nxt[i]   = '0;
          end
        end
        PEND_LO: begin
          if (btn_sync_p1[i]) begin
            state_nxt[i] = STABLE_HI;
          end else if (tick) begin
            if (cnt[i] >= CNT_LAST) begin
              state_nxt[i] = STABLE_LO;
              cnt_nxt[i]   = CNT_DONE;
            end else begin
              cnt_nxt[i] = cnt[i] + 1'b1;
            end
          end
        end
        default: state_nxt[i] = STABLE_LO;
      endcase
      level_nxt[i]   = (state_nxt[i] == STABLE_HI) || (state_nxt[i] == PEND_LO);
      press_nxt[i]   = (state[i] == PEND_HI) && (state_nxt[i] == STABLE_HI);
      release_nxt[i] = (state[i] == PEND_LO) && (state_nxt[i] == STABLE_LO);
    end
  end

  // Debounce state and saturating tick counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBTN; i++) begin
        state[i] <= STABLE_LO;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

`ifdef PMOD_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                           REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int RW = $clog2(RPT_MAX + 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;
  logic [RW-1:0] rpt_target;

  assign rpt_target = rpt_first ? RW'(REPEAT_DELAY_TICKS) : RW'(REPEAT_RATE_TICKS);
  // A repeat is only emitted if the button is still held after this edge.
  assign rpt_fire   = (state[ADD_IDX] == STABLE_HI) && (state_nxt[ADD_IDX] == STABLE_HI) &&
                      tick && ((rpt_cnt + 1'b1) == rpt_target);

  // Repeat timer: long initial delay, then the shorter rate; cleared whenever the hold ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (state[ADD_IDX] != STABLE_HI) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else if (tick) begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Route a repeat onto the add button's press lane.
  always_comb begin
    rpt_vec          = '0;
    rpt_vec[ADD_IDX] = rpt_fire;
  end

  assign capture = press_nxt[ADD_IDX] | rpt_fire;

  // ---- stage p2: registered levels, pulses and data capture ----
  // Data is taken from the same synchronized sample that decided the press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      data_q      <= '0;
      data_valid  <= 1'b0;
    end else begin
      btn_level   <= level_nxt;
      btn_press   <= press_nxt | rpt_vec;
      btn_release <= release_nxt;
      data_valid  <= capture;
      if (capture) begin
        data_q <= data_sync_p1;
      end
    end
  end

endmodule

// File: tb/tb_pmod_input_conditioner.sv
// Testbench for pmod_input_conditioner: directed scenarios plus random button
// and data activity, checked against a behavioural model through a scoreboard.
module tb_pmod_input_conditioner;

  localparam int TICK_DIV  = 4;
  localparam int DEB_TICKS = 3;
  localparam int NBTN      = 4;
  localparam int DW        = 4;
  localparam int ADD_IDX   = 1;
  localparam int RPT_DELAY = 5;
  localparam int RPT_RATE  = 2;

  logic            clk;
  logic            rst_n;
  logic [NBTN-1:0] btn_raw;
  logic [DW-1:0]   data_raw;
  logic            tick;
  logic [NBTN-1:0] btn_level, btn_press, btn_release;
  logic [DW-1:0]   data_q;
  logic            data_valid;

  pmod_input_conditioner #(
    .TICK_DIV(TICK_DIV), .DEBOUNCE_TICKS(DEB_TICKS), .NBTN(NBTN), .DW(DW),
    .ADD_IDX(ADD_IDX), .REPEAT_DELAY_TICKS(RPT_DELAY), .REPEAT_RATE_TICKS(RPT_RATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .data_raw(data_raw),
    .tick(tick), .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .data_q(data_q), .data_valid(data_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int              cyc;
    logic [NBTN-1:0] press;
    logic [NBTN-1:0] rel;
    logic            dv;
    logic [DW-1:0]   dq;
  } ev_t;

  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Model state: clock edges since reset, pin history, accepted levels,
  // how many ticks a differing level has survived, held time of the add button.
  int              m_edge;
  bit [NBTN-1:0]   m_s1, m_s2, m_level, m_run;
  bit [DW-1:0]     m_d1, m_d2, m_dq;
  int              m_ticks [NBTN];
  int              m_held;
  int              m_press_cnt [NBTN];
  int              dut_press_cnt [NBTN];
  int              dut_rel_cnt [NBTN];
  int              m_press_tot, dut_press_tot;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NBTN; i++) begin
      m_press_cnt[i]   = 0;
      dut_press_cnt[i] = 0;
      dut_rel_cnt[i]   = 0;
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tick"}, 32'(tick), 32'd0);
    check({name, "_level"}, 32'(btn_level), 32'd0);
    check({name, "_press"}, 32'(btn_press), 32'd0);
    check({name, "_release"}, 32'(btn_release), 32'd0);
    check({name, "_data_q"}, 32'(data_q), 32'd0);
    check({name, "_data_valid"}, 32'(data_valid), 32'd0);
  endtask

  // Reference model: steps once per clock edge on the pins as the bench drives them.
  always @(posedge clk or negedge rst_n) begin : model_step
    bit            tick_in;
    bit            fire;
    bit [NBTN-1:0] sync, prs, rls;
    bit [DW-1:0]   dsync;
    ev_t           e;
    if (!rst_n) begin
      m_edge  = 0;
      m_s1    = '0;
      m_s2    = '0;
      m_d1    = '0;
      m_d2    = '0;
      m_level = '0;
      m_run   = '0;
      m_dq    = '0;
      m_held  = 0;
      exp_q.delete();
    end else begin
      m_edge++;
      // Tick strobes follow every TICK_DIV-th edge; the decision here sees the previous edge's tick.
      tick_in = (m_edge > 1) && (((m_edge - 1) % TICK_DIV) == 0);
      sync  = m_s2;
      dsync = m_d2;
      m_s2  = m_s1;
      m_s1  = btn_raw;
      m_d2  = m_d1;
      m_d1  = data_raw;
      prs   = '0;
      rls   = '0;
      fire  = 1'b0;
`ifdef PMOD_AUTO_REPEAT_EN
      if (m_level[ADD_IDX] && !m_run[ADD_IDX] && sync[ADD_IDX]) begin
        if (tick_in) begin
          m_held++;
          fire = (m_held == RPT_DELAY) ||
                 ((m_held > RPT_DELAY) && (((m_held - RPT_DELAY) % RPT_RATE) == 0));
        end
      end else begin
        m_held = 0;
      end
`endif
      for (int i = 0; i < NBTN; i++) begin
        if (sync[i] != m_level[i]) begin
          if (!m_run[i]) begin
            m_run[i]   = 1'b1;
            m_ticks[i] = 0;
          end else if (tick_in) begin
            m_ticks[i]++;
            if (m_ticks[i] == DEB_TICKS) begin
              m_level[i] = sync[i];
              m_run[i]   = 1'b0;
              if (sync[i]) prs[i] = 1'b1;
              else         rls[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 1'b0;
        end
      end
      if (fire) prs[ADD_IDX] = 1'b1;
      if (prs[ADD_IDX]) m_dq = dsync;
      for (int i = 0; i < NBTN; i++) begin
        if (prs[i]) begin
          m_press_cnt[i]++;
          m_press_tot++;
        end
      end
      if ((prs != '0) || (rls != '0)) begin
        e.cyc   = m_edge;
        e.press = prs;
        e.rel   = rls;
        e.dv    = prs[ADD_IDX];
        e.dq    = m_dq;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: per-cycle level/tick/data checks and scoreboard matching of pulses.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst_n) begin
      check("tick", 32'(tick), ((m_edge > 0) && ((m_edge % TICK_DIV) == 0)) ? 32'd1 : 32'd0);
      check("btn_level", 32'(btn_level), 32'(m_level));
      check("data_q", 32'(data_q), 32'(m_dq));
      while ((exp_q.size() != 0) && (exp_q[0].cyc < m_edge)) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse: no DUT pulse, expected press %0h release %0h at edge %0d",
                 e.press, e.rel, e.cyc);
      end
      if ((btn_press != '0) || (btn_release != '0) || data_valid) begin
        for (int i = 0; i < NBTN; i++) begin
          if (btn_press[i]) begin
            dut_press_cnt[i]++;
            dut_press_tot++;
          end
          if (btn_release[i]) dut_rel_cnt[i]++;
        end
        if ((exp_q.size() == 0) || (exp_q[0].cyc != m_edge)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got press %0h release %0h valid %0b, expected none at edge %0d",
                   btn_press, btn_release, data_valid, m_edge);
        end else begin
          e = exp_q.pop_front();
          check("ev_press", 32'(btn_press), 32'(e.press));
          check("ev_release", 32'(btn_release), 32'(e.rel));
          check("ev_valid", 32'(data_valid), 32'(e.dv));
          check("ev_data_q", 32'(data_q), 32'(e.dq));
        end
      end else if ((exp_q.size() != 0) && (exp_q[0].cyc == m_edge)) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse: no DUT pulse, expected press %0h release %0h at edge %0d",
                 e.press, e.rel, e.cyc);
      end
    end
  end

  initial begin
    m_press_tot   = 0;
    dut_press_tot = 0;
    clear_counts();
    rst_n    = 1'b0;
    btn_raw  = '0;
    data_raw = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    wait_cyc(1);
    rst_n = 1'b1;
    #1;
    check_all_zero("after_release");

    // Add button held with data A: one press, one capture.
    wait_cyc(6);
    clear_counts();
    data_raw     = 4'hA;
    btn_raw[1]   = 1'b1;
    wait_cyc(24);
    check("s1_press_cnt", 32'(dut_press_cnt[1]), 32'd1);
    check("s1_level", 32'(btn_level[1]), 32'd1);
    check("s1_data_q", 32'(data_q), 32'hA);

    // Short bounce on button 0 is rejected.
    clear_counts();
    btn_raw[0] = 1'b1;
    wait_cyc(5);
    btn_raw[0] = 1'b0;
    wait_cyc(20);
    check("s2_press_cnt", 32'(dut_press_cnt[0]), 32'd0);
    check("s2_level", 32'(btn_level[0]), 32'd0);

    // Release of the add button: one release, data_q holds.
    clear_counts();
    data_raw   = 4'h5;
    btn_raw[1] = 1'b0;
    wait_cyc(24);
    check("s3_release_cnt", 32'(dut_rel_cnt[1]), 32'd1);
    check("s3_press_cnt", 32'(dut_press_cnt[1]), 32'd0);
    check("s3_data_q", 32'(data_q), 32'hA);
    check("s3_level", 32'(btn_level[1]), 32'd0);

    // Reset while button 2 is pending and button 3 is accepted.
    clear_counts();
    btn_raw[3] = 1'b1;
    wait_cyc(24);
    check("s4_level3", 32'(btn_level[3]), 32'd1);
    btn_raw[2] = 1'b1;
    wait_cyc(8);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    for (int k = 0; k < 3; k++) begin
      wait_cyc(1);
      check("reset_no_press", 32'(btn_press), 32'd0);
    end
    rst_n = 1'b1;
    wait_cyc(28);
    check("s4_press2_cnt", 32'(dut_press_cnt[2]), 32'd1);
    check("s4_press3_cnt", 32'(dut_press_cnt[3]), 32'd2);
    check("s4_level", 32'(btn_level), 32'hC);
    btn_raw = '0;
    wait_cyc(28);

    // Long hold of the add button with changing data.
    clear_counts();
    data_raw   = 4'h1;
    btn_raw[1] = 1'b1;
    wait_cyc(24);
    data_raw = 4'h2;
    wait_cyc(20);
    data_raw = 4'h3;
    wait_cyc(20);
`ifdef PMOD_AUTO_REPEAT_EN
    check("s5_press_cnt", 32'(dut_press_cnt[1]), 32'(m_press_cnt[1]));
`else
    check("s5_press_cnt", 32'(dut_press_cnt[1]), 32'd1);
`endif
    btn_raw[1] = 1'b0;
    wait_cyc(28);

    // Random activity: mixes bounces, accepts and simultaneous buttons.
    for (int it = 0; it < 80; it++) begin
      btn_raw  = NBTN'($urandom);
      data_raw = DW'($urandom);
      wait_cyc(int'($urandom_range(1, 40)));
    end
    btn_raw = '0;
    wait_cyc(40);
    check("total_press_cnt", 32'(dut_press_tot), 32'(m_press_tot));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
